// File: rtl/rob_flex.sv
// rob_flex: parametrised reorder buffer with in-order commit, memory handshake at head and commit-time mispredict flush
module rob_flex #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int N_WB  = 5,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic [4:0]            alloc_rd,
  input  logic [1:0]            alloc_kind,
  input  logic [N_WB-1:0]       wb_valid,
  input  logic [N_WB*TAG_W-1:0] wb_tag,
  input  logic [N_WB*XLEN-1:0]  wb_data,
  input  logic [N_WB-1:0]       wb_mispredict,
  output logic                  commit_valid,
  output logic [TAG_W-1:0]      commit_tag,
  output logic [4:0]            commit_rd,
  output logic [1:0]            commit_kind,
  output logic [XLEN-1:0]       commit_data,
  output logic                  mem_req,
  input  logic                  mem_resp,
  output logic                  flush,
  output logic [XLEN-1:0]       flush_pc,
  output logic [DEPTH-1:0]      done_vec,
  output logic [TAG_W:0]        count
);
  localparam logic [1:0] K_LOAD = 2'd1, K_STORE = 2'd2, K_BRANCH = 2'd3;
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   cnt;
  logic [DEPTH-1:0] busy, done, misp;
  logic [1:0]       kind_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0] wb_hit, wb_misp;
  logic [XLEN-1:0]  wb_val [DEPTH];
  logic             head_rdy, head_mem, alloc_fire;
  // scan ports high to low so the lowest matching port index overrides the rest
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wb_hit[e]  = 1'b0;
      wb_misp[e] = 1'b0;
      wb_val[e]  = '0;
      for (int i = N_WB - 1; i >= 0; i--) begin
        if (wb_valid[i] && wb_tag[i*TAG_W +: TAG_W] == TAG_W'(e)) begin
          wb_hit[e]  = busy[e];
          wb_misp[e] = wb_mispredict[i];
          wb_val[e]  = wb_data[i*XLEN +: XLEN];
        end
      end
    end
  end
  assign head_rdy     = busy[head] && done[head];
  assign head_mem     = kind_q[head] == K_LOAD || kind_q[head] == K_STORE;
  assign mem_req      = head_rdy && head_mem;
  assign commit_valid = head_rdy && (head_mem ? mem_resp : 1'b1);
  assign flush        = commit_valid && kind_q[head] == K_BRANCH && misp[head];
  assign flush_pc     = data_q[head];
  assign commit_tag   = head;
  assign commit_rd    = rd_q[head];
  assign commit_kind  = kind_q[head];
  assign commit_data  = data_q[head];
  assign alloc_ready  = cnt != (TAG_W+1)'(DEPTH) && !flush;
  assign alloc_tag    = tail;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign done_vec     = done;
  assign count        = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      busy <= '0;
      done <= '0;
      misp <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        kind_q[e] <= '0;
        rd_q[e]   <= '0;
        data_q[e] <= '0;
      end
    end else if (flush) begin
      busy <= '0;
      done <= '0;
      misp <= '0;
      head <= head + TAG_W'(1);
      tail <= head + TAG_W'(1);
      cnt  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_hit[e]) begin
          done[e]   <= 1'b1;
          misp[e]   <= wb_misp[e];
          data_q[e] <= wb_val[e];
        end
      end
      if (alloc_fire) begin
        busy[tail]   <= 1'b1;
        done[tail]   <= 1'b0;
        misp[tail]   <= 1'b0;
        kind_q[tail] <= alloc_kind;
        rd_q[tail]   <= alloc_rd;
        data_q[tail] <= '0;
        tail         <= tail + TAG_W'(1);
      end
      if (commit_valid) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + TAG_W'(1);
      end
      cnt <= cnt + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
    end
  end
endmodule

// File: tb/tb_rob_flex.sv
// tb_rob_flex: randomized scoreboard bench for rob_flex against a program-order queue model
module tb_rob_flex;
  localparam int DEPTH = 8, TAG_W = 3, N_WB = 5, XLEN = 32;
  logic                  clk = 0, rst = 1;
  logic                  alloc_valid = 0, alloc_ready;
  logic [TAG_W-1:0]      alloc_tag;
  logic [4:0]            alloc_rd = 0;
  logic [1:0]            alloc_kind = 0;
  logic [N_WB-1:0]       wb_valid = 0, wb_mispredict = 0;
  logic [N_WB*TAG_W-1:0] wb_tag = 0;
  logic [N_WB*XLEN-1:0]  wb_data = 0;
  logic                  commit_valid, mem_req, mem_resp = 0, flush;
  logic [TAG_W-1:0]      commit_tag;
  logic [4:0]            commit_rd;
  logic [1:0]            commit_kind;
  logic [XLEN-1:0]       commit_data, flush_pc;
  logic [DEPTH-1:0]      done_vec;
  logic [TAG_W:0]        count;

  rob_flex #(.DEPTH(DEPTH), .TAG_W(TAG_W), .N_WB(N_WB), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_rd(alloc_rd), .alloc_kind(alloc_kind), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_mispredict(wb_mispredict), .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_kind(commit_kind), .commit_data(commit_data), .mem_req(mem_req), .mem_resp(mem_resp),
    .flush(flush), .flush_pc(flush_pc), .done_vec(done_vec), .count(count));

  always #5 clk = ~clk;

  typedef struct {logic [TAG_W-1:0] tag; logic [4:0] rd; logic [1:0] kind; bit done; bit misp; logic [XLEN-1:0] data;} ent_t;
  typedef struct {logic [TAG_W-1:0] tag; logic [4:0] rd; logic [1:0] kind; logic [XLEN-1:0] data; bit fl;} exp_t;
  ent_t q[$];
  exp_t sb[$];
  logic [TAG_W-1:0] m_tail = 0;
  int checks = 0, errors = 0, ncommit = 0, nflush = 0, nfull = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: in-flight instructions kept oldest-first; head is q[0].
  task automatic model_cycle();
    bit cv, mr, fl, rdy;
    logic [DEPTH-1:0] dv;
    exp_t e;
    #1;
    mr  = q.size() > 0 && q[0].done && (q[0].kind == 2'd1 || q[0].kind == 2'd2);
    cv  = q.size() > 0 && q[0].done && (mr ? mem_resp : 1'b1);
    fl  = cv && q[0].kind == 2'd3 && q[0].misp;
    rdy = q.size() < DEPTH && !fl;
    dv  = '0;
    foreach (q[j]) if (q[j].done) dv[q[j].tag] = 1'b1;
    if (q.size() == DEPTH) nfull++;
    chk("alloc_ready", 64'(alloc_ready), 64'(rdy));
    chk("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_req", 64'(mem_req), 64'(mr));
    chk("done_vec", 64'(done_vec), 64'(dv));
    if (cv) begin
      e.tag = q[0].tag; e.rd = q[0].rd; e.kind = q[0].kind; e.data = q[0].data; e.fl = fl;
      sb.push_back(e);
      ncommit++;
    end
    if (fl) begin
      m_tail = q[0].tag + TAG_W'(1);
      q.delete();
      nflush++;
    end else begin
      foreach (q[j])
        for (int i = 0; i < N_WB; i++)
          if (wb_valid[i] && wb_tag[i*TAG_W +: TAG_W] == q[j].tag) begin
            q[j].done = 1'b1;
            q[j].misp = wb_mispredict[i];
            q[j].data = wb_data[i*XLEN +: XLEN];
            break;
          end
      if (cv) void'(q.pop_front());
      if (alloc_valid && rdy) begin
        q.push_back('{m_tail, alloc_rd, alloc_kind, 1'b0, 1'b0, '0});
        m_tail = m_tail + TAG_W'(1);
      end
    end
  endtask

  task automatic rand_inputs(input int p_alloc, input int p_wb);
    alloc_valid = $urandom_range(0, 99) < p_alloc;
    alloc_rd    = 5'($urandom);
    alloc_kind  = 2'($urandom);
    mem_resp    = $urandom_range(0, 1) == 1;
    for (int i = 0; i < N_WB; i++) begin
      wb_valid[i]      = $urandom_range(0, 99) < p_wb;
      wb_mispredict[i] = $urandom_range(0, 3) == 0;
      wb_data[i*XLEN +: XLEN] = $urandom;
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wb_tag[i*TAG_W +: TAG_W] = q[$urandom_range(0, q.size() - 1)].tag;
      else
        wb_tag[i*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, DEPTH - 1));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst && commit_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit actual tag=%0h expected none at %0t", commit_tag, $time);
      end else begin
        e = sb.pop_front();
        chk("commit_tag", 64'(commit_tag), 64'(e.tag));
        chk("commit_rd", 64'(commit_rd), 64'(e.rd));
        chk("commit_kind", 64'(commit_kind), 64'(e.kind));
        chk("commit_data", 64'(commit_data), 64'(e.data));
        chk("flush", 64'(flush), 64'(e.fl));
        if (e.fl) chk("flush_pc", 64'(flush_pc), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    chk("rst_alloc_tag", 64'(alloc_tag), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_done_vec", 64'(done_vec), 64'(0));
    rst = 0;
    @(negedge clk);
    // fill to full with no writebacks, then keep requesting while full
    for (int c = 0; c < 12; c++) begin
      rand_inputs(100, 0);
      model_cycle();
      @(negedge clk);
    end
    for (int c = 0; c < 600; c++) begin
      rand_inputs(70, 20);
      model_cycle();
      @(negedge clk);
    end
    for (int c = 0; c < 600; c++) begin
      rand_inputs(50, 50);
      model_cycle();
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      rand_inputs(100, 0);
      model_cycle();
      @(negedge clk);
    end
    alloc_valid = 0;
    wb_valid = 0;
    mem_resp = 0;
    #4;
    chk("sb_drain", 64'(sb.size()), 64'(0));
    chk("pre_rst_count", 64'(count), 64'(q.size()));
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("async_rst_mem_req", 64'(mem_req), 64'(0));
    chk("async_rst_done_vec", 64'(done_vec), 64'(0));
    chk("async_rst_alloc_ready", 64'(alloc_ready), 64'(1));
    if (ncommit == 0 || nflush == 0 || nfull == 0) begin
      checks++;
      errors++;
      $display("FAIL coverage commits=%0d flushes=%0d full_cycles=%0d expected all nonzero", ncommit, nflush, nfull);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
